// File: rtl/led_sr_ctrl_if.sv
// Client request ports and serial pad signals of the LED shift-register controller.
// The controller uses the slave modport; clients and pads sit on the master side.
interface led_sr_ctrl_if;
    logic [7:0] a_val;
    logic       a_go;
    logic       a_rdy;
    logic [7:0] b_val;
    logic       b_go;
    logic       b_rdy;
    logic       sr_data;
    logic       sr_clk;
    logic       sr_latch;
    logic       busy;

    modport master (
        output a_val, a_go, b_val, b_go,
        input  a_rdy, b_rdy, sr_data, sr_clk, sr_latch, busy
    );

    modport slave (
        input  a_val, a_go, b_val, b_go,
        output a_rdy, b_rdy, sr_data, sr_clk, sr_latch, busy
    );
endinterface

// File: rtl/led_sr_ctrl.sv
// Shares one 16-bit serial LED/control shift register between two byte clients.
// Define LED_SR_INIT_EN to shift out an all-zero image automatically after reset.
module led_sr_ctrl #(
    parameter int DIV = 2
) (
    input  logic          clk,
    input  logic          rst,
    led_sr_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;

`ifdef LED_SR_INIT_EN
    localparam logic DIRTY_RST = 1'b1;
`else
    localparam logic DIRTY_RST = 1'b0;
`endif

    localparam logic [7:0] HC_MAX = 8'(DIV - 1);

    state_t      state;
    logic [7:0]  img_a;
    logic [7:0]  img_b;
    logic        dirty;
    logic [15:0] shreg;
    logic [7:0]  hc;
    logic [3:0]  bitcnt;
    logic        cap_a;
    logic        cap_b;

    // A held go recaptures only every second cycle because rdy blocks it.
    assign cap_a = bus.a_go & ~bus.a_rdy;
    assign cap_b = bus.b_go & ~bus.b_rdy;

    // Per-client capture into the shadow bytes with a one-cycle acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            img_a     <= 8'h00;
            img_b     <= 8'h00;
            bus.a_rdy <= 1'b0;
            bus.b_rdy <= 1'b0;
        end else begin
            bus.a_rdy <= cap_a;
            bus.b_rdy <= cap_b;
            if (cap_a)
                img_a <= bus.a_val;
            if (cap_b)
                img_b <= bus.b_val;
        end
    end

    // Transfer scheduler: load image, shift 16 bits MSB first, then latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            dirty        <= DIRTY_RST;
            shreg        <= 16'h0000;
            hc           <= 8'h00;
            bitcnt       <= 4'h0;
            bus.sr_data  <= 1'b0;
            bus.sr_clk   <= 1'b0;
            bus.sr_latch <= 1'b0;
            bus.busy     <= 1'b0;
        end else begin
            // A capture in the LOAD cycle keeps dirty set for the next transfer.
            if (state == LOAD)
                dirty <= 1'b0;
            if (cap_a | cap_b)
                dirty <= 1'b1;

            unique case (state)
                IDLE: begin
                    if (dirty) begin
                        state    <= LOAD;
                        bus.busy <= 1'b1;
                    end
                end
                LOAD: begin
                    shreg       <= {img_b, img_a};
                    bus.sr_data <= img_b[7];
                    bus.sr_clk  <= 1'b0;
                    hc          <= 8'h00;
                    bitcnt      <= 4'h0;
                    state       <= SHIFT;
                end
                SHIFT: begin
                    if (hc != HC_MAX) begin
                        hc <= hc + 8'd1;
                    end else begin
                        hc <= 8'h00;
                        if (!bus.sr_clk) begin
                            bus.sr_clk <= 1'b1;
                        end else if (bitcnt == 4'd15) begin
                            bus.sr_clk   <= 1'b0;
                            bus.sr_data  <= 1'b0;
                            bus.sr_latch <= 1'b1;
                            state        <= LATCH;
                        end else begin
                            bus.sr_clk  <= 1'b0;
                            bitcnt      <= bitcnt + 4'd1;
                            shreg       <= {shreg[14:0], 1'b0};
                            bus.sr_data <= shreg[14];
                        end
                    end
                end
                LATCH: begin
                    if (hc != HC_MAX) begin
                        hc <= hc + 8'd1;
                    end else begin
                        hc           <= 8'h00;
                        bus.sr_latch <= 1'b0;
                        bus.busy     <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/led_sr_ctrl.md
# led_sr_ctrl

Shares the single board-level serial LED/control shift register (two chained 8-bit 74HC595-style stages) between two 8-bit clients and drives its serial pins. Each client has a `val`/`go`/`rdy` request port. A client's value is captured into a per-client shadow byte. The scheduler shifts the combined 16-bit image out whenever any shadow has changed. It sits between the LED blink logic (client A) and a second control client (client B) on one side, and the `sr_*` pads on the other.

## Interface
Parameters:
- `DIV`, 2 — half-period of `sr_clk` and width of `sr_latch` pulse, in `clk` cycles; legal range 1..255.

Ports:
- `clk`  in  1  — single system clock.
- `rst`  in  1  — reset, synchronous, active-high.
- `a_val`  in  8  — client A requested byte.
- `a_go`  in  1  — client A update request, level.
- `a_rdy`  out  1  — client A capture acknowledge, 1-cycle pulse.
- `b_val`  in  8  — client B requested byte.
- `b_go`  in  1  — client B update request, level.
- `b_rdy`  out  1  — client B capture acknowledge, 1-cycle pulse.
- `sr_data`  out  1  — serial data to the first register stage.
- `sr_clk`  out  1  — shift clock; data is sampled on its rising edge.
- `sr_latch`  out  1  — storage-register latch pulse, active-high.
- `busy`  out  1  — a transfer is in progress.

## Operation
- Shadows `img_a` and `img_b` are 8-bit registers. A `dirty` flag marks pending output.
- Capture, independent per client X:
  - When `X_go & ~X_rdy`: `img_X <= X_val`, `X_rdy <= 1`, `dirty <= 1`.
  - Otherwise `X_rdy <= 0`.
  - A held `go` therefore recaptures every second cycle. A client must drop `go` on seeing `rdy`.
- Simultaneous A and B requests are both captured in the same cycle; no arbitration loss.
- FSM states are IDLE, LOAD, SHIFT, LATCH.
  - IDLE → LOAD when `dirty`.
  - LOAD (1 cycle):
    - Loads the shifter with `{img_b, img_a}`, using shadow values as of that cycle.
    - Clears `dirty`, unless a capture occurs in the same cycle; set wins, so the new value goes out in the next transfer.
    - Clears the bit counter. Then → SHIFT.
  - SHIFT: 16 bits, MSB first. `img_b[7]` goes out first and `img_a[0]` last. Each bit has two phases:
    - low phase: `sr_clk=0`, `sr_data` = current bit, for DIV cycles;
    - high phase: `sr_clk=1`, for DIV cycles, with `sr_data` held stable.
    - The shifter advances at the end of the high phase.
  - SHIFT → LATCH after the 16th high phase.
  - LATCH: `sr_clk=0`, `sr_latch=1` for DIV cycles. Then → IDLE with `sr_latch=0`.
- Captures during SHIFT or LATCH only update the shadows and set `dirty`; the transfer in flight is unaffected. Any number of captures during one transfer coalesce into exactly one following transfer with the latest values.
- `busy` is 1 in LOAD, SHIFT and LATCH, and 0 in IDLE.
- All outputs are registered.

## Timing
- Reset values: `a_rdy=0`, `b_rdy=0`, `sr_data=0`, `sr_clk=0`, `sr_latch=0`, `busy=0`, shadows 0, FSM IDLE.
- Reset value of `dirty` is 0, or 1 with `LED_SR_INIT_EN` (see Configuration).
- Capture to `rdy`: `rdy` is high the cycle after the `go` sample.
- Capture in IDLE to `busy`: `busy` rises 2 cycles after the `go` sample (capture edge, then LOAD).
- Transfer length from LOAD entry to IDLE: 1 + 32·DIV + DIV cycles. This is 67 cycles at DIV=2 and 34 at DIV=1.
- Back-to-back transfers: IDLE lasts exactly 1 cycle between the end of LATCH and the next LOAD when `dirty` is already set.
- Half-period counter is 8 bits and bit counter is 4 bits. Both wrap only under FSM control; no free-running wrap.
- `rst` asserted mid-transfer: the next edge forces the reset values. The partial transfer is abandoned without a latch pulse, and pending shadows are lost.

## Configuration
- `LED_SR_INIT_EN` defined:
  - `dirty` resets to 1, so an all-zero image is shifted and latched automatically after reset.
  - `busy` rises 1 cycle after `rst` deasserts.
- `LED_SR_INIT_EN` undefined:
  - `dirty` resets to 0, and no transfer occurs until the first client capture.

## Test plan
- DIV=2, A requests `a_val=8'hA5` once:
  - `a_rdy` pulses 1 cycle after the `go` sample.
  - 16 rising edges of `sr_clk` carry 0x00A5 MSB first.
  - `sr_latch` is high for 2 cycles.
  - `busy` is high for 67 cycles.
- DIV=2, A=0x3C and B=0xF0 requested in the same cycle: a single transfer of 0xF03C, and both `rdy` pulse in the same cycle.
- During a transfer of 0x0001:
  - B captures 0x11, then 0x22, then A captures 0x80.
  - Required: exactly one following transfer of 0x2280, starting 1 cycle after the first latch ends.
- `a_go` held high for 10 cycles: `a_rdy` toggles 1,0,1,0…, and only one transfer follows if it starts after the last capture.
- `rst` asserted at bit 7 of SHIFT:
  - All outputs take their reset values on the next edge, and no `sr_latch` pulse occurs.
  - With `LED_SR_INIT_EN` defined, a 0x0000 transfer starts after release.
- DIV=1: a transfer of 0xFFFF gives an `sr_clk` period of 2 cycles, `busy` high for 34 cycles, and `sr_data` constant 1 across SHIFT.
